// File: rtl/tdm_demux1x4.sv
// rtl/tdm_demux1x4.sv - serial TDM demultiplexer, one bit stream to four CH_W-bit channels
// Optional feature macro: TDM_PARITY_EN (one even-parity bit appended to every slot).
module tdm_demux1x4 #(
    parameter int CH_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            din,
    input  logic            en,
    input  logic            fsync,
    output logic [CH_W-1:0] y0,
    output logic [CH_W-1:0] y1,
    output logic [CH_W-1:0] y2,
    output logic [CH_W-1:0] y3,
    output logic            frame_done,
    output logic            locked,
    output logic            sync_err,
    output logic [3:0]      par_err
);

`ifdef TDM_PARITY_EN
    localparam int SLOT_W = CH_W + 1;
`else
    localparam int SLOT_W = CH_W;
`endif
    localparam int BC_W = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            r_state;
    logic [BC_W-1:0]   r_bit_cnt;
    logic [1:0]        r_slot_cnt;
    logic [SLOT_W-1:0] r_shift;
    logic [CH_W-1:0]   r_stage0;
    logic [CH_W-1:0]   r_stage1;
    logic [CH_W-1:0]   r_stage2;
    logic [CH_W-1:0]   r_y0;
    logic [CH_W-1:0]   r_y1;
    logic [CH_W-1:0]   r_y2;
    logic [CH_W-1:0]   r_y3;
    logic              r_frame_done;
    logic              r_locked;
    logic              r_sync_err;

    logic [SLOT_W-1:0] w_shift_next;
    logic [CH_W-1:0]   w_data;
    logic              w_slot_last;
    logic              w_frame_start;

    // Data bits sit MSB-first at the top of the slot; a parity bit, if any, is the LSB.
    assign w_shift_next  = {r_shift[SLOT_W-2:0], din};
    assign w_data        = w_shift_next[SLOT_W-1 -: CH_W];
    assign w_slot_last   = (r_bit_cnt == BC_W'(SLOT_W - 1));
    assign w_frame_start = (r_bit_cnt == '0) && (r_slot_cnt == 2'd0);

`ifdef TDM_PARITY_EN
    logic [2:0] r_stage_pe;
    logic [3:0] r_par_err;
    logic       w_perr;

    // Even parity: XOR over data plus parity bit must be zero.
    assign w_perr = ^w_shift_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage_pe <= '0;
            r_par_err  <= '0;
        end else if (en && r_state == RUN && (w_frame_start == fsync) && w_slot_last) begin
            case (r_slot_cnt)
                2'd0: r_stage_pe[0] <= w_perr;
                2'd1: r_stage_pe[1] <= w_perr;
                2'd2: r_stage_pe[2] <= w_perr;
                default: r_par_err  <= {w_perr, r_stage_pe};
            endcase
        end
    end

    assign par_err = r_par_err;
`else
    assign par_err = 4'b0000;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= HUNT;
            r_bit_cnt    <= '0;
            r_slot_cnt   <= 2'd0;
            r_shift      <= '0;
            r_stage0     <= '0;
            r_stage1     <= '0;
            r_stage2     <= '0;
            r_y0         <= '0;
            r_y1         <= '0;
            r_y2         <= '0;
            r_y3         <= '0;
            r_frame_done <= 1'b0;
            r_locked     <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
            if (en) begin
                if (r_state == HUNT) begin
                    if (fsync) begin
                        r_shift    <= w_shift_next;
                        r_bit_cnt  <= BC_W'(1);
                        r_slot_cnt <= 2'd0;
                        r_state    <= RUN;
                        r_locked   <= 1'b1;
                    end
                end else if (w_frame_start && !fsync) begin
                    r_sync_err <= 1'b1;
                    r_state    <= HUNT;
                    r_locked   <= 1'b0;
                end else if (!w_frame_start && fsync) begin
                    // Misplaced sync: drop the partial frame and restart on this bit.
                    r_sync_err <= 1'b1;
                    r_shift    <= w_shift_next;
                    r_bit_cnt  <= BC_W'(1);
                    r_slot_cnt <= 2'd0;
                end else begin
                    r_shift <= w_shift_next;
                    if (w_slot_last) begin
                        r_bit_cnt  <= '0;
                        r_slot_cnt <= r_slot_cnt + 2'd1;
                        case (r_slot_cnt)
                            2'd0: r_stage0 <= w_data;
                            2'd1: r_stage1 <= w_data;
                            2'd2: r_stage2 <= w_data;
                            default: begin
                                r_y0         <= r_stage0;
                                r_y1         <= r_stage1;
                                r_y2         <= r_stage2;
                                r_y3         <= w_data;
                                r_frame_done <= 1'b1;
                            end
                        endcase
                    end else begin
                        r_bit_cnt <= r_bit_cnt + BC_W'(1);
                    end
                end
            end
        end
    end

    assign y0         = r_y0;
    assign y1         = r_y1;
    assign y2         = r_y2;
    assign y3         = r_y3;
    assign frame_done = r_frame_done;
    assign locked     = r_locked;
    assign sync_err   = r_sync_err;

endmodule
